intersection_ctrl: RTL

- Sequences two `traffic_light`-style signal heads at a four-way intersection: north-south (NS) and east-west (EW).
- Only one direction is ever non-red. Each change of right-of-way passes through an all-red clearance interval.
- Also services latched pedestrian crossing requests with per-direction walk outputs.
- Sits above the per-head lamp drivers. All phase timing is counted in `clk` ticks (1 s per tick at the bench timescale).

---
 rtl/intersection_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/intersection_ctrl.sv
// -----------------------------------------------------------------------------
// intersection_ctrl
//
// Sequences the north-south (NS) and east-west (EW) signal heads of a four-way
// intersection. Right-of-way alternates between the two directions, and every
// change passes through an all-red clearance interval. Latched pedestrian
// requests are served with a walk signal at the start of the matching green.
// All phase lengths are counted in clk cycles.
//
// Optional feature, enabled by defining INTERSECTION_PREEMPT_EN:
//   adds input 'preempt'. While it is high, a running green is cut short to
//   its yellow, and the controller then holds all-red (timer frozen at
//   ALL_RED). Walk outputs are suppressed and pending requests are kept.
//
// Parameters:
//   GREEN    green length in cycles (>= 1)
//   YELLOW   yellow length in cycles (>= 1)
//   ALL_RED  all-red clearance length in cycles (>= 1)
//   WALK     walk length at the start of a green (1..GREEN)
//   CNT_W    phase timer width; must hold max(GREEN, YELLOW, ALL_RED)
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   ped_req_ns  pedestrian request to cross with NS traffic
//   ped_req_ew  pedestrian request to cross with EW traffic
//   preempt     (INTERSECTION_PREEMPT_EN only) emergency preemption
//   ns_red, ns_yellow, ns_green   NS lamps (registered)
//   ew_red, ew_yellow, ew_green   EW lamps (registered)
//   walk_ns, walk_ew              pedestrian walk outputs (registered)
//   phase       current state encoding (0..5), for debug
// -----------------------------------------------------------------------------
module intersection_ctrl #(
   parameter int GREEN   = 12,
   parameter int YELLOW  = 4,
   parameter int ALL_RED = 2,
   parameter int WALK    = 8,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req_ns,
   input  logic       ped_req_ew,
`ifdef INTERSECTION_PREEMPT_EN
   input  logic       preempt,
`endif
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      AR_NS = 3'd0,   // all red, NS is next
      NS_G  = 3'd1,
      NS_Y  = 3'd2,
      AR_EW = 3'd3,   // all red, EW is next
      EW_G  = 3'd4,
      EW_Y  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] T_GREEN   = CNT_W'(GREEN);
   localparam logic [CNT_W-1:0] T_YELLOW  = CNT_W'(YELLOW);
   localparam logic [CNT_W-1:0] T_ALL_RED = CNT_W'(ALL_RED);
   localparam logic [CNT_W-1:0] T_ONE     = CNT_W'(1);
   // In a green the timer reads GREEN on the first cycle and counts down, so
   // walk carries into the next cycle only while timer > GREEN-WALK+1.
   localparam logic [CNT_W-1:0] T_WALK_END = CNT_W'(GREEN - WALK + 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic             pend_ns, pend_ew;
   logic             pend_ns_nxt, pend_ew_nxt;
   logic             walk_ns_nxt, walk_ew_nxt;
   logic             hold;
   logic             last;

`ifdef INTERSECTION_PREEMPT_EN
   assign hold = preempt;
`else
   assign hold = 1'b0;
`endif

   assign last  = (timer == T_ONE);
   assign phase = state;

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer - T_ONE;
      pend_ns_nxt = pend_ns | ped_req_ns;
      pend_ew_nxt = pend_ew | ped_req_ew;
      walk_ns_nxt = 1'b0;
      walk_ew_nxt = 1'b0;

      case (state)
         AR_NS: begin
            if (hold) begin
               timer_nxt = T_ALL_RED;
            end else if (last) begin
               state_nxt   = NS_G;
               timer_nxt   = T_GREEN;
               // Serve only a request latched before this edge; one arriving
               // right now waits for the next NS green.
               walk_ns_nxt = pend_ns;
               pend_ns_nxt = ped_req_ns;
            end
         end
         NS_G: begin
            if (hold || last) begin
               state_nxt = NS_Y;
               timer_nxt = T_YELLOW;
            end else begin
               walk_ns_nxt = walk_ns && (timer > T_WALK_END);
            end
         end
         NS_Y: begin
            if (last) begin
               state_nxt = AR_EW;
               timer_nxt = T_ALL_RED;
            end
         end
         AR_EW: begin
            if (hold) begin
               timer_nxt = T_ALL_RED;
            end else if (last) begin
               state_nxt   = EW_G;
               timer_nxt   = T_GREEN;
               walk_ew_nxt = pend_ew;
               pend_ew_nxt = ped_req_ew;
            end
         end
         EW_G: begin
            if (hold || last) begin
               state_nxt = EW_Y;
               timer_nxt = T_YELLOW;
            end else begin
               walk_ew_nxt = walk_ew && (timer > T_WALK_END);
            end
         end
         EW_Y: begin
            if (last) begin
               state_nxt = AR_NS;
               timer_nxt = T_ALL_RED;
            end
         end
         default: begin
            // Encodings 6 and 7 are unreachable; recover to a safe all-red.
            state_nxt = AR_NS;
            timer_nxt = T_ALL_RED;
         end
      endcase

      if (hold) begin
         walk_ns_nxt = 1'b0;
         walk_ew_nxt = 1'b0;
      end
   end

   // NOTE: every register here, including the pedestrian latches, is cleared
   // by the asynchronous reset so a mid-phase reset discards all history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= AR_NS;
         timer     <= T_ALL_RED;
         pend_ns   <= 1'b0;
         pend_ew   <= 1'b0;
         walk_ns   <= 1'b0;
         walk_ew   <= 1'b0;
         ns_red    <= 1'b1;
         ns_yellow <= 1'b0;
         ns_green  <= 1'b0;
         ew_red    <= 1'b1;
         ew_yellow <= 1'b0;
         ew_green  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // same pre-edge values regardless of statement order.
         state     <= state_nxt;
         timer     <= timer_nxt;
         pend_ns   <= pend_ns_nxt;
         pend_ew   <= pend_ew_nxt;
         walk_ns   <= walk_ns_nxt;
         walk_ew   <= walk_ew_nxt;
         // Lamps decode the next state so they line up with 'phase'.
         ns_green  <= (state_nxt == NS_G);
         ns_yellow <= (state_nxt == NS_Y);
         ns_red    <= (state_nxt != NS_G) && (state_nxt != NS_Y);
         ew_green  <= (state_nxt == EW_G);
         ew_yellow <= (state_nxt == EW_Y);
         ew_red    <= (state_nxt != EW_G) && (state_nxt != EW_Y);
      end
   end

endmodule
